// File: rtl/sram_arb_pkg.sv
// Shared constants, FSM state and request record for the two-port SRAM arbiter/controller.
package sram_arb_pkg;
   localparam int ADDR_W     = 10;
   localparam int DATA_W     = 32;
   localparam int NUM_WMASKS = 4;
   localparam int CNT_W      = 4;

   typedef enum logic {
      IDLE   = 1'b0,
      RD_RSP = 1'b1
   } state_e;

   typedef struct packed {
      logic                  we;
      logic [ADDR_W-1:0]     addr;
      logic [DATA_W-1:0]     wdata;
      logic [NUM_WMASKS-1:0] wmask;
   } req_t;

   function automatic logic [DATA_W-1:0] mask_bytes(logic [DATA_W-1:0] d, logic [NUM_WMASKS-1:0] m);
      logic [DATA_W-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_WMASKS; i++) r[8*i +: 8] = m[i] ? d[8*i +: 8] : 8'h00;
      return r;
   endfunction
endpackage

// File: rtl/sram_arb_ctrl_if.sv
// Requester-side request/response bundle; one instance per requester port.
interface sram_arb_ctrl_if;
   import sram_arb_pkg::*;

   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_W-1:0]     req_addr;
   logic [DATA_W-1:0]     req_wdata;
   logic [NUM_WMASKS-1:0] req_wmask;
   logic                  rsp_valid;
   logic [DATA_W-1:0]     rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_wmask,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_wmask,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/sram_arb_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter with zero-cycle grant and a burst counter.
module rr_arb2
   import sram_arb_pkg::*;
#(
   parameter int BURST_MAX = 4
) (
   input  logic       clk0,
   input  logic       rst0,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   logic             last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             win_b;

   // A zero count means the previous cycle granted nobody, so a tie falls back to plain round-robin.
   always_comb begin
      gnt_o  = 2'b00;
      win_b  = ~last_q;
      last_d = last_q;
      cnt_d  = '0;
      if (cnt_q != '0 && cnt_q < CNT_W'(BURST_MAX)) win_b = last_q;
      unique case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = win_b ? 2'b10 : 2'b01;
         default: gnt_o = 2'b00;
      endcase
      if (gnt_o != 2'b00) begin
         last_d = gnt_o[1];
         if (gnt_o[1] == last_q && cnt_q != '0) cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
         else cnt_d = CNT_W'(1);
      end
   end

   always_ff @(posedge clk0) begin
      if (rst0) begin
         last_q <= 1'b1;
         cnt_q  <= '0;
      end else begin
         last_q <= last_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/sram_arb_ctrl.sv
// Two-requester SRAM controller: arbitration, macro muxing, 1-cycle read response routing.
// Optional read parity on the spare bit is built when SRAM_ARB_PARITY_EN is defined.
module sram_arb_ctrl
   import sram_arb_pkg::*;
#(
   parameter int BURST_MAX = 4
) (
   input  logic                  clk0,
   input  logic                  rst0,
   sram_arb_ctrl_if.slave        a,
   sram_arb_ctrl_if.slave        b,
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [NUM_WMASKS-1:0] sram_wmask0,
   output logic                  sram_spare_wen0,
   output logic [ADDR_W-1:0]     sram_addr0,
   output logic [DATA_W:0]       sram_din0,
   input  logic [DATA_W:0]       sram_dout0,
   output logic                  parity_err
);

   req_t   req_a, req_b, req_sel;
   logic   [1:0] gnt;
   logic   acc, rd_acc, rsp_live;
   state_e state_q, state_d;
   logic   rsp_b_q, rsp_b_d;

   assign req_a = '{we: a.req_we, addr: a.req_addr, wdata: a.req_wdata, wmask: a.req_wmask};
   assign req_b = '{we: b.req_we, addr: b.req_addr, wdata: b.req_wdata, wmask: b.req_wmask};

   rr_arb2 #(.BURST_MAX(BURST_MAX)) u_arb (
      .clk0  (clk0),
      .rst0  (rst0),
      .req_i ({b.req_valid, a.req_valid} & {2{~rst0}}),
      .gnt_o (gnt)
   );

   assign a.req_ready  = gnt[0];
   assign b.req_ready  = gnt[1];
   assign req_sel      = gnt[1] ? req_b : req_a;
   assign acc          = |gnt;
   assign rd_acc       = acc && !req_sel.we;
   assign sram_csb0    = !acc;
   assign sram_web0    = !(acc && req_sel.we);
   assign sram_addr0   = req_sel.addr;
   assign sram_wmask0  = req_sel.we ? req_sel.wmask : '0;

   always_comb begin
      state_d = IDLE;
      rsp_b_d = rsp_b_q;
      if (rd_acc) begin
         state_d = RD_RSP;
         rsp_b_d = gnt[1];
      end
   end

   always_ff @(posedge clk0) begin
      if (rst0) begin
         state_q <= IDLE;
         rsp_b_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rsp_b_q <= rsp_b_d;
      end
   end

   // Reset in the response cycle drops the outstanding read.
   assign rsp_live    = (state_q == RD_RSP) && !rst0;
   assign a.rsp_valid = rsp_live && !rsp_b_q;
   assign b.rsp_valid = rsp_live && rsp_b_q;
   assign a.rsp_rdata = a.rsp_valid ? sram_dout0[DATA_W-1:0] : '0;
   assign b.rsp_rdata = b.rsp_valid ? sram_dout0[DATA_W-1:0] : '0;

`ifdef SRAM_ARB_PARITY_EN
   logic [2**ADDR_W-1:0] full_q;
   logic                 rd_full_q, perr_q;

   function automatic logic even_par(logic [DATA_W-1:0] d);
      return ^d;
   endfunction

   assign sram_din0       = {even_par(mask_bytes(req_sel.wdata, req_sel.wmask)), req_sel.wdata};
   assign sram_spare_wen0 = acc && req_sel.we && (&req_sel.wmask);
   assign parity_err      = perr_q;

   // full_q marks words whose spare bit holds valid parity (last data-changing write was full-word).
   always_ff @(posedge clk0) begin
      if (rst0) begin
         full_q    <= '0;
         rd_full_q <= 1'b0;
         perr_q    <= 1'b0;
      end else begin
         if (acc && req_sel.we && (&req_sel.wmask)) full_q[req_sel.addr] <= 1'b1;
         else if (acc && req_sel.we && (|req_sel.wmask)) full_q[req_sel.addr] <= 1'b0;
         if (rd_acc) rd_full_q <= full_q[req_sel.addr];
         if (rsp_live && rd_full_q && (^sram_dout0)) perr_q <= 1'b1;
      end
   end
`else
   logic unused_spare;
   assign unused_spare    = sram_dout0[DATA_W];
   assign sram_din0       = {1'b0, req_sel.wdata};
   assign sram_spare_wen0 = 1'b0;
   assign parity_err      = 1'b0;
`endif

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Bench for sram_arb_ctrl: directed pins plus randomized traffic against a transaction-level model.
module tb_sram_arb_ctrl;
   import sram_arb_pkg::*;

   localparam int BURST_MAX = 4;

   logic clk0 = 1'b0;
   logic rst0;
   always #5 clk0 = ~clk0;

   sram_arb_ctrl_if a_if ();
   sram_arb_ctrl_if b_if ();

   logic                  sram_csb0, sram_web0, sram_spare_wen0, parity_err;
   logic [NUM_WMASKS-1:0] sram_wmask0;
   logic [ADDR_W-1:0]     sram_addr0;
   logic [DATA_W:0]       sram_din0;
   logic [DATA_W:0]       sram_dout0;

   sram_arb_ctrl #(.BURST_MAX(BURST_MAX)) dut (
      .clk0            (clk0),
      .rst0            (rst0),
      .a               (a_if),
      .b               (b_if),
      .sram_csb0       (sram_csb0),
      .sram_web0       (sram_web0),
      .sram_wmask0     (sram_wmask0),
      .sram_spare_wen0 (sram_spare_wen0),
      .sram_addr0      (sram_addr0),
      .sram_din0       (sram_din0),
      .sram_dout0      (sram_dout0),
      .parity_err      (parity_err)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Macro model: one access per posedge, 1-cycle read latency, spare bit flip hook.
   logic [DATA_W:0] mem [2**ADDR_W];
   logic            flip_spare;
   initial begin
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] = '0;
      sram_dout0 = '0;
   end
   always @(posedge clk0) begin
      if (!sram_csb0) begin
         if (!sram_web0) begin
            for (int i = 0; i < NUM_WMASKS; i++)
               if (sram_wmask0[i]) mem[sram_addr0][8*i +: 8] <= sram_din0[8*i +: 8];
            if (sram_spare_wen0) mem[sram_addr0][DATA_W] <= sram_din0[DATA_W];
         end else begin
            sram_dout0 <= mem[sram_addr0] ^ {flip_spare, {DATA_W{1'b0}}};
         end
      end
   end

   // Reference model state
   logic [DATA_W-1:0] ref_mem  [2**ADDR_W];
   bit                ref_full [2**ADDR_W];
   int                m_last = 1;
   int                m_run  = 0;
   bit                m_pend = 0, m_pend_bad = 0, m_perr = 0;
   int                m_pend_port = 0;
   logic [DATA_W-1:0] m_pend_data = '0;
   initial for (int i = 0; i < 2**ADDR_W; i++) begin ref_mem[i] = '0; ref_full[i] = 0; end

   task automatic model_cycle();
      int                    g;
      bit                    va, vb, ea, eb, we;
      logic [ADDR_W-1:0]     ad;
      logic [DATA_W-1:0]     wd, masked;
      logic [NUM_WMASKS-1:0] wm;
      va = a_if.req_valid;
      vb = b_if.req_valid;
      g  = -1;
      if (!rst0) begin
         if (va && vb) g = (m_run > 0 && m_run < BURST_MAX) ? m_last : 1 - m_last;
         else if (va) g = 0;
         else if (vb) g = 1;
      end
      if (g == 1) begin we = b_if.req_we; ad = b_if.req_addr; wd = b_if.req_wdata; wm = b_if.req_wmask; end
      else begin we = a_if.req_we; ad = a_if.req_addr; wd = a_if.req_wdata; wm = a_if.req_wmask; end
      masked = '0;
      for (int i = 0; i < NUM_WMASKS; i++) if (wm[i]) masked[8*i +: 8] = wd[8*i +: 8];

      check("ready_a", a_if.req_ready, g == 0);
      check("ready_b", b_if.req_ready, g == 1);
      check("csb", sram_csb0, g < 0);
      check("web", sram_web0, !(g >= 0 && we));
      if (g >= 0) check("addr", sram_addr0, ad);
      if (g >= 0 && we) begin
         check("wmask", sram_wmask0, wm);
         check("din", sram_din0[DATA_W-1:0], wd);
`ifdef SRAM_ARB_PARITY_EN
         check("din_spare", sram_din0[DATA_W], ^masked);
         check("spare_wen", sram_spare_wen0, wm == '1);
`else
         check("din_spare", sram_din0[DATA_W], 1'b0);
         check("spare_wen", sram_spare_wen0, 1'b0);
`endif
      end

      ea = !rst0 && m_pend && m_pend_port == 0;
      eb = !rst0 && m_pend && m_pend_port == 1;
      check("rsp_valid_a", a_if.rsp_valid, ea);
      check("rsp_valid_b", b_if.rsp_valid, eb);
      if (ea) check("rsp_rdata_a", a_if.rsp_rdata, m_pend_data);
      if (eb) check("rsp_rdata_b", b_if.rsp_rdata, m_pend_data);
      if (rst0) begin
         check("rst_rdata_a", a_if.rsp_rdata, 0);
         check("rst_rdata_b", b_if.rsp_rdata, 0);
      end
      check("parity_err", parity_err, m_perr);

      if (rst0) begin
         m_last = 1; m_run = 0; m_pend = 0; m_perr = 0;
         for (int i = 0; i < 2**ADDR_W; i++) ref_full[i] = 0;
      end else begin
         if (m_pend && m_pend_bad) m_perr = 1;
         m_pend      = (g >= 0) && !we;
         m_pend_port = g;
         m_pend_data = ref_mem[ad];
         m_pend_bad  = ref_full[ad] && flip_spare;
         if (g >= 0 && we) begin
            for (int i = 0; i < NUM_WMASKS; i++) if (wm[i]) ref_mem[ad][8*i +: 8] = wd[8*i +: 8];
            if (wm == '1) ref_full[ad] = 1;
            else if (wm != '0) ref_full[ad] = 0;
         end
         if (g < 0) m_run = 0;
         else begin
            if (g == m_last && m_run > 0) m_run = (m_run < 15) ? m_run + 1 : 15;
            else m_run = 1;
            m_last = g;
         end
      end
   endtask

   initial begin
      @(posedge clk0);
      forever begin
         @(negedge clk0);
         model_cycle();
      end
   end

   task automatic next();
      @(posedge clk0);
      #1;
   endtask

   task automatic set_req(input bit port, input bit v, input bit we, input logic [ADDR_W-1:0] ad,
                          input logic [DATA_W-1:0] wd, input logic [NUM_WMASKS-1:0] m);
      if (port) begin
         b_if.req_valid = v; b_if.req_we = we; b_if.req_addr = ad; b_if.req_wdata = wd; b_if.req_wmask = m;
      end else begin
         a_if.req_valid = v; a_if.req_we = we; a_if.req_addr = ad; a_if.req_wdata = wd; a_if.req_wmask = m;
      end
   endtask

   task automatic idle_both();
      set_req(0, 0, 0, '0, '0, '0);
      set_req(1, 0, 0, '0, '0, '0);
   endtask

   task automatic do_reset();
      idle_both();
      rst0 = 1'b1;
      next();
      next();
      rst0 = 1'b0;
   endtask

   logic [8:0] burst_pat;

   initial begin
      rst0       = 1'b1;
      flip_spare = 1'b0;
      idle_both();
      repeat (3) @(posedge clk0);
      @(negedge clk0);
      check("reset_ready_a", a_if.req_ready, 0);
      check("reset_ready_b", b_if.req_ready, 0);
      check("reset_csb", sram_csb0, 1);
      check("reset_web", sram_web0, 1);
      check("reset_rsp_a", a_if.rsp_valid, 0);
      check("reset_perr", parity_err, 0);

      // Write then read 0x005 from a only
      next(); rst0 = 1'b0;
      set_req(0, 1, 1, 10'h005, 32'hDEADBEEF, 4'hF);
      next(); set_req(0, 1, 0, 10'h005, '0, '0);
      @(negedge clk0); check("rd5_ready", a_if.req_ready, 1);
      next(); set_req(0, 0, 0, '0, '0, '0);
      @(negedge clk0);
      check("rd5_valid", a_if.rsp_valid, 1);
      check("rd5_data", a_if.rsp_rdata, 32'hDEADBEEF);
      check("rd5_b_quiet", b_if.rsp_valid, 0);
      next(); @(negedge clk0); check("rd5_single_pulse", a_if.rsp_valid, 0);

      // Byte-masked write over zero
      next(); set_req(0, 1, 1, 10'h010, 32'h0, 4'hF);
      next(); set_req(0, 1, 1, 10'h010, 32'h11223344, 4'h2);
      next(); set_req(0, 1, 0, 10'h010, '0, '0);
      next(); set_req(0, 0, 0, '0, '0, '0);
      @(negedge clk0); check("mask_rd_data", a_if.rsp_rdata, 32'h00003300);

      // Back-to-back reads on a then b
      next(); set_req(0, 1, 1, 10'h001, 32'hA1A1A1A1, 4'hF);
      next(); set_req(0, 1, 1, 10'h002, 32'hB2B2B2B2, 4'hF);
      next(); set_req(0, 1, 0, 10'h001, '0, '0);
      next(); set_req(0, 0, 0, '0, '0, '0); set_req(1, 1, 0, 10'h002, '0, '0);
      @(negedge clk0);
      check("b2b_a_valid", a_if.rsp_valid, 1);
      check("b2b_a_data", a_if.rsp_rdata, 32'hA1A1A1A1);
      check("b2b_b_quiet", b_if.rsp_valid, 0);
      next(); set_req(1, 0, 0, '0, '0, '0);
      @(negedge clk0);
      check("b2b_b_valid", b_if.rsp_valid, 1);
      check("b2b_b_data", b_if.rsp_rdata, 32'hB2B2B2B2);
      check("b2b_a_quiet", a_if.rsp_valid, 0);

      // Burst pattern with both ports continuously valid
      next(); do_reset();
      burst_pat = 9'b0_1111_0000;
      set_req(0, 1, 0, 10'h000, '0, '0);
      set_req(1, 1, 0, 10'h000, '0, '0);
      for (int i = 0; i < 9; i++) begin
         @(negedge clk0);
         check("burst_grant_b", b_if.req_ready, burst_pat[i]);
         check("burst_grant_a", a_if.req_ready, !burst_pat[i]);
         next();
      end
      idle_both();

      // Reset right after a read accept
      next(); set_req(0, 1, 0, 10'h005, '0, '0);
      next(); set_req(0, 0, 0, '0, '0, '0); rst0 = 1'b1;
      @(negedge clk0);
      check("rst_rd_valid", a_if.rsp_valid, 0);
      check("rst_rd_csb", sram_csb0, 1);
      check("rst_rd_rdata", a_if.rsp_rdata, 0);
      next(); rst0 = 1'b0;
      @(negedge clk0); check("rst_rd_late", a_if.rsp_valid, 0);

`ifdef SRAM_ARB_PARITY_EN
      next(); set_req(0, 1, 1, 10'h007, 32'h12345678, 4'hF);
      next(); set_req(0, 1, 0, 10'h007, '0, '0); flip_spare = 1'b1;
      next(); set_req(0, 0, 0, '0, '0, '0); flip_spare = 1'b0;
      next(); @(negedge clk0); check("perr_set", parity_err, 1);
      next(); next(); @(negedge clk0); check("perr_sticky", parity_err, 1);
      next(); do_reset();
      @(negedge clk0); check("perr_cleared", parity_err, 0);
`endif

      // Randomized traffic with occasional reset
      for (int c = 0; c < 3000; c++) begin
         next();
         rst0 = ($urandom_range(0, 63) == 0);
         for (int p = 0; p < 2; p++) begin
            logic [NUM_WMASKS-1:0] m;
            logic [ADDR_W-1:0]     ad;
            m  = ($urandom_range(0, 3) == 0) ? 4'hF : NUM_WMASKS'($urandom_range(0, 15));
            ad = ADDR_W'($urandom_range(0, 15)) | (($urandom_range(0, 7) == 0) ? 10'h3F0 : 10'h000);
            set_req(p[0], $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, ad, $urandom, m);
         end
      end
      next(); rst0 = 1'b0; idle_both();
      next(); next();
      @(negedge clk0);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
